// File: rtl/mem_mon_pkg.sv
// Shared definitions for the memory access profiler: alarm FSM encodings
// and the width of the per-window event counters.
package mem_mon_pkg;

    typedef enum logic [1:0] {
        NORMAL  = 2'd0,
        PENDING = 2'd1,
        ALARM   = 2'd2
    } alarm_state_t;

    // A window can hold 2**window_log + 1 transactions, so one extra bit is needed.
    function automatic int win_cnt_width(input int window_log);
        return window_log + 1;
    endfunction

endpackage

// File: rtl/mem_mon_ema.sv
// mem_mon_ema: one exponential moving average of 0..2 events per step, full scale 2**EMA_SHIFT.
// Latency: rate reflects a step on the clock edge that samples it (1 cycle from the handshake).
// Backpressure: none; steps whenever step is high.
module mem_mon_ema #(
    parameter int EMA_SHIFT = 10
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    input  logic                 step,
    input  logic                 dual,
    input  logic [1:0]           events,
    output logic [EMA_SHIFT:0]   rate
);

    localparam int ACC_W = 2 * EMA_SHIFT + 1;
    localparam int EXT_W = ACC_W + 2;
    localparam logic [EXT_W-1:0] ACC_MAX = EXT_W'(1) << (2 * EMA_SHIFT);

    logic [ACC_W-1:0] acc_q;
    logic [EXT_W-1:0] acc_ext;
    logic [EXT_W-1:0] gain;
    logic [EXT_W-1:0] decay;
    logic [EXT_W-1:0] acc_sum;

    assign acc_ext = EXT_W'(acc_q);
    assign gain    = EXT_W'(events) << EMA_SHIFT;
    assign decay   = dual ? ((acc_ext >> EMA_SHIFT) << 1) : (acc_ext >> EMA_SHIFT);
    // decay never exceeds acc itself, so no underflow; a dual step at full scale
    // can overshoot by one LSB and is clamped back to 100%.
    assign acc_sum = acc_ext + gain - decay;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            acc_q <= '0;
        end else if (step) begin
            acc_q <= (acc_sum > ACC_MAX) ? ACC_MAX[ACC_W-1:0] : acc_sum[ACC_W-1:0];
        end
    end

    assign rate = acc_q[EMA_SHIFT +: EMA_SHIFT+1];

endmodule

// File: rtl/mem_access_profiler.sv
// mem_access_profiler: passive AW/AR monitor; switch/miss EMAs, window snapshots, page-miss alarm.
// Latency: EMAs/snapshots/alarm update on the edge after the handshake; win_valid the cycle after close.
// Backpressure: none, handshakes are only observed. MEM_PROFILER_BANK_VALID_EN adds per-bank valid bits.
module mem_access_profiler
    import mem_mon_pkg::*;
#(
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int BANK_LSB       = 13,
    parameter int BANK_BITS      = 4,
    parameter int ROW_LSB        = 17,
    parameter int ROW_WIDTH      = 15,
    parameter int EMA_SHIFT      = 10,
    parameter int WINDOW_LOG     = 8,
    parameter int HOLD_WINDOWS   = 2
) (
    input  logic                      aclk,
    input  logic                      aresetn,
    input  logic [AXI_ADDR_WIDTH-1:0] aw_addr,
    input  logic                      aw_valid,
    input  logic                      aw_ready,
    input  logic [AXI_ADDR_WIDTH-1:0] ar_addr,
    input  logic                      ar_valid,
    input  logic                      ar_ready,
    input  logic                      win_clear,
    input  logic [WINDOW_LOG:0]       thr_hi,
    input  logic [WINDOW_LOG:0]       thr_lo,
    output logic [EMA_SHIFT:0]        rd_wr_switch,
    output logic [EMA_SHIFT:0]        miss_rate,
    output logic [WINDOW_LOG:0]       win_reads,
    output logic [WINDOW_LOG:0]       win_writes,
    output logic [WINDOW_LOG:0]       win_switches,
    output logic [WINDOW_LOG:0]       win_misses,
    output logic                      win_valid,
    output logic                      alarm
);

    localparam int WCW   = win_cnt_width(WINDOW_LOG);
    localparam int NBANK = 1 << BANK_BITS;
    localparam logic [WCW-1:0] WIN_SIZE = WCW'(1) << WINDOW_LOG;
    localparam logic [3:0]     HOLD_TGT = 4'(HOLD_WINDOWS);

    typedef struct packed {
        logic [WCW-1:0] reads;
        logic [WCW-1:0] writes;
        logic [WCW-1:0] switches;
        logic [WCW-1:0] misses;
    } win_cnt_t;

    logic rd_acc, wr_acc, any_acc, dual_acc;
    logic prev_was_write;
    logic first_is_wr;
    logic switch_evt;

    logic [BANK_BITS-1:0] rd_bank, wr_bank, first_bank, second_bank;
    logic [ROW_WIDTH-1:0] rd_row, wr_row, first_row, second_row;
    logic [ROW_WIDTH-1:0] cur_page [NBANK];
    logic first_known, second_known;
    logic miss_first, miss_second;
    logic [1:0] miss_evt, sw_evt;

    logic [WCW-1:0] txn_cnt, txn_inc, txn_sum;
    win_cnt_t       win_q, win_nxt, snap_q;
    logic           win_close;
    logic           win_valid_q;

    alarm_state_t state_q, state_nxt;
    logic [3:0]   hold_q, hold_nxt;

    logic unused_addr_bits;
    assign unused_addr_bits = ^{ar_addr, aw_addr};

    assign rd_acc   = ar_valid && ar_ready;
    assign wr_acc   = aw_valid && aw_ready;
    assign any_acc  = rd_acc || wr_acc;
    assign dual_acc = rd_acc && wr_acc;

    // On a dual cycle the type matching the previous transaction goes first,
    // so the pair always contributes exactly one turnaround.
    assign first_is_wr = dual_acc ? prev_was_write : wr_acc;
    assign switch_evt  = dual_acc || (any_acc && (wr_acc != prev_was_write));

    assign rd_bank = ar_addr[BANK_LSB +: BANK_BITS];
    assign wr_bank = aw_addr[BANK_LSB +: BANK_BITS];
    assign rd_row  = ar_addr[ROW_LSB +: ROW_WIDTH];
    assign wr_row  = aw_addr[ROW_LSB +: ROW_WIDTH];

    assign first_bank  = first_is_wr ? wr_bank : rd_bank;
    assign first_row   = first_is_wr ? wr_row  : rd_row;
    assign second_bank = first_is_wr ? rd_bank : wr_bank;
    assign second_row  = first_is_wr ? rd_row  : wr_row;

`ifdef MEM_PROFILER_BANK_VALID_EN
    logic [NBANK-1:0] bank_vld;

    assign first_known  = bank_vld[first_bank];
    assign second_known = bank_vld[second_bank];

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            bank_vld <= '0;
        end else begin
            if (any_acc)  bank_vld[first_bank]  <= 1'b1;
            if (dual_acc) bank_vld[second_bank] <= 1'b1;
        end
    end
`else
    assign first_known  = 1'b1;
    assign second_known = 1'b1;
`endif

    // A same-bank second access sees the row the first one just opened.
    assign miss_first  = any_acc && (!first_known || (first_row != cur_page[first_bank]));
    assign miss_second = dual_acc &&
                         ((first_bank == second_bank) ? (second_row != first_row)
                                                      : (!second_known || (second_row != cur_page[second_bank])));

    assign miss_evt = {1'b0, miss_first} + {1'b0, miss_second};
    assign sw_evt   = {1'b0, switch_evt};

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            for (int b = 0; b < NBANK; b++) cur_page[b] <= '0;
        end else begin
            if (any_acc)  cur_page[first_bank]  <= first_row;
            if (dual_acc) cur_page[second_bank] <= second_row;
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            prev_was_write <= 1'b0;
        end else if (any_acc) begin
            prev_was_write <= dual_acc ? !prev_was_write : wr_acc;
        end
    end

    mem_mon_ema #(.EMA_SHIFT(EMA_SHIFT)) u_switch_ema (
        .aclk    (aclk),
        .aresetn (aresetn),
        .step    (any_acc),
        .dual    (dual_acc),
        .events  (sw_evt),
        .rate    (rd_wr_switch)
    );

    mem_mon_ema #(.EMA_SHIFT(EMA_SHIFT)) u_miss_ema (
        .aclk    (aclk),
        .aresetn (aresetn),
        .step    (any_acc),
        .dual    (dual_acc),
        .events  (miss_evt),
        .rate    (miss_rate)
    );

    assign txn_inc = dual_acc ? WCW'(2) : WCW'(1);
    assign txn_sum = txn_cnt + (any_acc ? txn_inc : '0);

    // The closing cycle's transactions are folded into the closing window.
    always_comb begin
        win_nxt          = win_q;
        win_nxt.reads    = win_q.reads    + WCW'(rd_acc);
        win_nxt.writes   = win_q.writes   + WCW'(wr_acc);
        win_nxt.switches = win_q.switches + WCW'(switch_evt);
        win_nxt.misses   = win_q.misses   + WCW'(miss_evt);
    end

    assign win_close = any_acc && !win_clear && (txn_sum >= WIN_SIZE);

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            txn_cnt     <= '0;
            win_q       <= '0;
            snap_q      <= '0;
            win_valid_q <= 1'b0;
        end else begin
            win_valid_q <= win_close;
            if (win_clear || win_close) begin
                txn_cnt <= '0;
                win_q   <= '0;
            end else if (any_acc) begin
                txn_cnt <= txn_sum;
                win_q   <= win_nxt;
            end
            if (win_close) snap_q <= win_nxt;
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q <= NORMAL;
            hold_q  <= '0;
        end else begin
            state_q <= state_nxt;
            hold_q  <= hold_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        hold_nxt  = hold_q;
        if (win_clear) begin
            state_nxt = NORMAL;
            hold_nxt  = '0;
        end else if (win_close) begin
            case (state_q)
                NORMAL: begin
                    if (win_nxt.misses >= thr_hi) begin
                        hold_nxt  = 4'd1;
                        state_nxt = (HOLD_TGT == 4'd1) ? ALARM : PENDING;
                    end
                end
                PENDING: begin
                    if (win_nxt.misses >= thr_hi) begin
                        hold_nxt = hold_q + 4'd1;
                        if ((hold_q + 4'd1) == HOLD_TGT) state_nxt = ALARM;
                    end else begin
                        state_nxt = NORMAL;
                        hold_nxt  = '0;
                    end
                end
                ALARM: begin
                    if (win_nxt.misses < thr_lo) begin
                        state_nxt = NORMAL;
                        hold_nxt  = '0;
                    end
                end
                default: begin
                    state_nxt = NORMAL;
                    hold_nxt  = '0;
                end
            endcase
        end
    end

    assign win_reads    = snap_q.reads;
    assign win_writes   = snap_q.writes;
    assign win_switches = snap_q.switches;
    assign win_misses   = snap_q.misses;
    assign win_valid    = win_valid_q;
    assign alarm        = (state_q == ALARM);

endmodule
